// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N:1 valid/ready stream mux with packet lock and round-robin or fixed select
module stream_mux_rr #(
    parameter int WIDTH   = 8,
    parameter int N       = 4,
    parameter int SELW    = $clog2(N),
    parameter int RR_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [SELW:0]   N_EXT   = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST_CH = SELW'(N-1);

    state_t            state;
    logic [SELW-1:0]   lock_ch;
    logic [SELW-1:0]   rr_ptr;
    logic [SELW-1:0]   grant;
    logic              grant_ok;
    logic              can_load;
    logic              xfer;
    logic              grant_last;
    logic [WIDTH-1:0]  grant_data;
    logic [SELW:0]     cand;

    assign can_load = !out_valid | out_ready;
    assign xfer     = |(in_valid & in_ready);

    // Round-robin search runs from the highest offset down so the channel
    // closest to rr_ptr wins; the wrap is a compare because N may not be 2^k.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        cand     = '0;
        if (state == LOCKED) begin
            grant    = lock_ch;
            grant_ok = 1'b1;
        end else if (RR_MODE != 0) begin
            grant_ok = |in_valid;
            for (int k = N - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr} + (SELW+1)'(k);
                if (cand >= N_EXT) begin
                    cand = cand - N_EXT;
                end
                if (in_valid[cand[SELW-1:0]]) begin
                    grant = cand[SELW-1:0];
                end
            end
        end else begin
            grant    = sel;
            grant_ok = ({1'b0, sel} < N_EXT);
        end
    end

    // Loop-based mux keeps an out-of-range sel from indexing past in_data;
    // in_ready is held low while rst is asserted.
    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                grant_last  = in_last[i];
                in_ready[i] = can_load & grant_ok & !rst;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lock_ch   <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            if (can_load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= grant_data;
                    out_last <= grant_last;
                    out_ch   <= grant;
                end
            end
            if (xfer) begin
                if (state == IDLE && !grant_last) begin
                    state   <= LOCKED;
                    lock_ch <= grant;
                end else if (state == LOCKED && grant_last) begin
                    state <= IDLE;
                end
                if (grant_last) begin
                    rr_ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - scoreboard bench for stream_mux_rr in three configurations
module tb_stream_mux_rr;

    typedef struct {
        logic [7:0] ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    // N=4 round-robin instance
    logic [31:0] d4;
    logic [3:0]  v4, l4, rdy4;
    logic [1:0]  sel4, och4;
    logic [7:0]  od4;
    logic        ov4, ol4, ordy4;
    // N=5 fixed-select instance
    logic [39:0] d5;
    logic [4:0]  v5, l5, rdy5;
    logic [2:0]  sel5, och5;
    logic [7:0]  od5;
    logic        ov5, ol5, ordy5;
    // N=3 round-robin instance
    logic [23:0] d3;
    logic [2:0]  v3, l3, rdy3;
    logic [1:0]  sel3, och3;
    logic [7:0]  od3;
    logic        ov3, ol3, ordy3;

    logic [8:0] src4 [4][$];
    logic [8:0] src3 [3][$];
    beat_t      exp4 [$];
    beat_t      exp3 [$];

    stream_mux_rr #(.WIDTH(8), .N(4), .RR_MODE(1)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_last(l4), .in_ready(rdy4),
        .sel(sel4), .out_data(od4), .out_valid(ov4), .out_last(ol4), .out_ch(och4), .out_ready(ordy4)
    );
    stream_mux_rr #(.WIDTH(8), .N(5), .RR_MODE(0)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(d5), .in_valid(v5), .in_last(l5), .in_ready(rdy5),
        .sel(sel5), .out_data(od5), .out_valid(ov5), .out_last(ol5), .out_ch(och5), .out_ready(ordy5)
    );
    stream_mux_rr #(.WIDTH(8), .N(3), .RR_MODE(1)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_last(l3), .in_ready(rdy3),
        .sel(sel3), .out_data(od3), .out_valid(ov3), .out_last(ol3), .out_ch(och3), .out_ready(ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic put4(input int ch, input logic [7:0] data, input logic last);
        beat_t b;
        src4[ch].push_back({last, data});
        b.ch = 8'(ch); b.data = data; b.last = last;
        exp4.push_back(b);
    endtask

    task automatic put3(input int ch, input logic [7:0] data, input logic last);
        beat_t b;
        src3[ch].push_back({last, data});
        b.ch = 8'(ch); b.data = data; b.last = last;
        exp3.push_back(b);
    endtask

    task automatic step4();
        logic [3:0] acc;
        beat_t      e;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            v4[i]         = (src4[i].size() > 0);
            d4[i*8 +: 8]  = v4[i] ? src4[i][0][7:0] : 8'h00;
            l4[i]         = v4[i] ? src4[i][0][8] : 1'b0;
        end
        #1;
        acc = v4 & rdy4;
        if (ov4 && ordy4) begin
            if (exp4.size() == 0) begin
                check("n4 unexpected beat", 32'(od4), 32'hFFFF_FFFF);
            end else begin
                e = exp4.pop_front();
                check("n4 out_ch", 32'(och4), 32'(e.ch));
                check("n4 out_data", 32'(od4), 32'(e.data));
                check("n4 out_last", 32'(ol4), 32'(e.last));
            end
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) void'(src4[i].pop_front());
        end
    endtask

    task automatic step3();
        logic [2:0] acc;
        beat_t      e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            v3[i]         = (src3[i].size() > 0);
            d3[i*8 +: 8]  = v3[i] ? src3[i][0][7:0] : 8'h00;
            l3[i]         = v3[i] ? src3[i][0][8] : 1'b0;
        end
        #1;
        acc = v3 & rdy3;
        if (ov3 && ordy3) begin
            if (exp3.size() == 0) begin
                check("n3 unexpected beat", 32'(od3), 32'hFFFF_FFFF);
            end else begin
                e = exp3.pop_front();
                check("n3 out_ch", 32'(och3), 32'(e.ch));
                check("n3 out_data", 32'(od3), 32'(e.data));
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) void'(src3[i].pop_front());
        end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b1;
        d4 = 32'hA5A5_A5A5; v4 = 4'hF; l4 = 4'hF; sel4 = 2'd0; ordy4 = 1'b1;
        d5 = '0; v5 = 5'h1F; l5 = 5'h1F; sel5 = 3'd0; ordy5 = 1'b1;
        d3 = '0; v3 = '0; l3 = '0; sel3 = 2'd0; ordy3 = 1'b1;

        // reset values, with inputs valid to show in_ready stays low
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 32'(ov4), 0);
        check("rst out_data", 32'(od4), 0);
        check("rst out_ch", 32'(och4), 0);
        check("rst out_last", 32'(ol4), 0);
        check("rst in_ready n4", 32'(rdy4), 0);
        check("rst in_ready n5", 32'(rdy5), 0);
        check("rst out_valid n5", 32'(ov5), 0);
        v4 = '0; l4 = '0; v5 = '0; l5 = '0;
        @(negedge clk);
        rst = 1'b0;

        // all channels, single-beat packets: rotation 0,1,2,3 at 1 beat/cycle
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) put4(c, 8'(8'h10 * (r + 1) + c), 1'b1);
        repeat (9) step4();
        check("rr drained", 32'(exp4.size()), 0);
        #1;
        check("rr out_valid drops", 32'(ov4), 0);

        // packet lock on ch1 while ch2 waits
        put4(1, 8'hA1, 1'b0);
        put4(1, 8'hA2, 1'b0);
        put4(1, 8'hA3, 1'b1);
        put4(2, 8'hB2, 1'b1);
        repeat (5) step4();
        check("lock drained", 32'(exp4.size()), 0);

        // backpressure holds output and blocks input
        for (int i = 0; i < 4; i++) put4(3, 8'(8'hC0 + i), 1'b1);
        step4();
        ordy4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step4();
            #1;
            check("bp out_valid", 32'(ov4), 1);
            check("bp out_data", 32'(od4), 32'hC0);
            check("bp out_ch", 32'(och4), 3);
            check("bp in_ready", 32'(rdy4), 0);
        end
        ordy4 = 1'b1;
        repeat (4) step4();
        check("bp drained", 32'(exp4.size()), 0);

        // fixed select: out-of-range sel grants nothing
        @(negedge clk);
        sel5 = 3'd6; v5 = 5'h1F; l5 = 5'h1F; d5 = 40'h1122334455;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sel6 in_ready", 32'(rdy5), 0);
            @(posedge clk);
            #1;
            check("sel6 out_valid", 32'(ov5), 0);
            @(negedge clk);
        end
        sel5 = 3'd4; v5 = 5'b10000; l5 = 5'b10000; d5 = '0; d5[39:32] = 8'h5A;
        #1;
        check("sel4 in_ready", 32'(rdy5), 32'b10000);
        @(posedge clk);
        #1;
        check("sel4 out_valid", 32'(ov5), 1);
        check("sel4 out_data", 32'(od5), 32'h5A);
        check("sel4 out_ch", 32'(och5), 4);
        check("sel4 out_last", 32'(ol5), 1);

        // sel change while locked is ignored until the packet ends
        @(negedge clk);
        sel5 = 3'd1; v5 = 5'b00110; l5 = 5'b00100; d5 = '0; d5[15:8] = 8'h61; d5[23:16] = 8'h72;
        #1;
        check("lock5 in_ready a", 32'(rdy5), 32'b00010);
        @(posedge clk);
        #1;
        check("lock5 data a", 32'(od5), 32'h61);
        @(negedge clk);
        sel5 = 3'd2; d5[15:8] = 8'h62; l5 = 5'b00110;
        #1;
        check("lock5 in_ready b", 32'(rdy5), 32'b00010);
        @(posedge clk);
        #1;
        check("lock5 data b", 32'(od5), 32'h62);
        check("lock5 ch b", 32'(och5), 1);
        @(negedge clk);
        v5 = 5'b00100;
        #1;
        check("lock5 in_ready c", 32'(rdy5), 32'b00100);
        @(posedge clk);
        #1;
        check("lock5 data c", 32'(od5), 32'h72);
        check("lock5 ch c", 32'(och5), 2);
        @(negedge clk);
        v5 = '0;

        // reset mid-packet on ch3 with rr_ptr moved off zero
        put4(0, 8'h70, 1'b1);
        put4(3, 8'hD1, 1'b0);
        put4(3, 8'hD2, 1'b0);
        put4(3, 8'hD3, 1'b1);
        repeat (3) step4();
        ordy4 = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) src4[i].delete();
        exp4.delete();
        repeat (2) step4();
        #1;
        check("mid-rst out_valid", 32'(ov4), 0);
        rst = 1'b0;
        ordy4 = 1'b1;
        put4(0, 8'h80, 1'b1);
        put4(3, 8'h83, 1'b1);
        repeat (3) step4();
        check("post-rst drained", 32'(exp4.size()), 0);

        // N=3 wrap: rr_ptr=2 with ch0/ch2 valid, then rr_ptr=1
        put3(1, 8'h31, 1'b1);
        step3();
        put3(2, 8'h42, 1'b1);
        put3(0, 8'h40, 1'b1);
        repeat (2) step3();
        put3(1, 8'h51, 1'b1);
        put3(2, 8'h52, 1'b1);
        put3(0, 8'h50, 1'b1);
        repeat (4) step3();
        check("wrap drained", 32'(exp3.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
